// File: rtl/mem_stream_reader.sv
// Streams a burst of words out of a registered-output RAM port through a 2-entry
// skid FIFO, issuing at most one read per cycle while keeping the FIFO from overflowing.
module mem_stream_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [ADDR_W:0]            rem_q, rem_d;
    logic                       inflight_q;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0][DATA_W-1:0]     buf_q;
    logic                       len0_q;
    logic                       pop, issue, start_ok, last_pop;
    logic [2:0]                 occ;

    assign pop       = m_valid_o & m_ready_i;
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = buf_q[rd_ptr_q];
    // Occupancy the FIFO will have next cycle before any new issue lands.
    assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign cnt_d     = occ[1:0];
    assign start_ok  = (state_q == IDLE) & start_i & ~rst_i;
    assign last_pop  = (state_q == FLUSH) & pop & (cnt_q == 2'd1) & ~inflight_q;

    assign busy_o    = (state_q != IDLE);
    assign done_o    = len0_q | last_pop;
    assign ram_en_o  = issue;
    assign ram_we_o  = 1'b0;
    assign ram_din_o = '0;

    // The first read goes out in the start cycle itself so data reaches the FIFO two cycles later.
    always_comb begin
        issue      = 1'b0;
        ram_addr_o = addr_q;
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        case (state_q)
            IDLE: begin
                if (start_ok && (len_i != '0)) begin
                    issue      = 1'b1;
                    ram_addr_o = addr_i;
                    addr_d     = addr_i + ADDR_W'(1);
                    rem_d      = len_i - (ADDR_W+1)'(1);
                    state_d    = (len_i == (ADDR_W+1)'(1)) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (occ < 3'd2) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            len0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            cnt_q      <= cnt_d;
            len0_q     <= start_ok & (len_i == '0);
            if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
            if (pop)        rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // FIFO storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && inflight_q) buf_q[wr_ptr_q] <= ram_dout_i;
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a table of bursts against a RAM holding mem[k]=k,
// plus a hand-written mid-burst reset sequence.
module tb_mem_stream_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_i, start_i, m_ready_i;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W:0]   len_i;
    logic              busy_o, done_o, ram_en_o, ram_we_o, m_valid_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_din_o, m_data_o;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i)
    );

    // Registered-read RAM model
    always @(posedge clk) begin
        if (ram_en_o) ram_dout <= mem[ram_addr_o];
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int addr;
        int len;
        int mode;      // 0: ready always, 1: random, 2: ready from cycle 3
        int exp_done;  // cycle of done_o relative to start cycle, -1 = only must occur
        int repulse;   // cycle to re-pulse start_i with other args, -1 = none
    } vec_t;

    function automatic logic rdy(input int mode, input int c);
        if (mode == 1) return logic'($urandom_range(0, 1));
        if (mode == 2) return (c >= 3);
        return 1'b1;
    endfunction

    task automatic run_burst(input vec_t v);
        int issued = 0, popped = 0, done_cyc = -1, done_cnt = 0;
        int budget = v.len * 8 + 40;
        logic prev_stall = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start_i   = (c == 0) || (c == v.repulse);
            addr_i    = (c == 0) ? ADDR_W'(v.addr) : ADDR_W'(40);
            len_i     = (c == 0) ? (ADDR_W+1)'(v.len) : (ADDR_W+1)'(4);
            m_ready_i = rdy(v.mode, c);
            #1;
            if (c == 1) check("busy_after_start", int'(busy_o), int'(v.len != 0));
            if (prev_stall) begin
                check("stall_valid", int'(m_valid_o), 1);
                check("stall_data", int'(m_data_o), int'(prev_data));
            end
            if (ram_en_o) begin
                check("ram_addr", int'(ram_addr_o), (v.addr + issued) % DEPTH);
                check("ram_we", int'(ram_we_o), 0);
                issued++;
                check("occupancy_le_2", int'(issued - popped - int'(m_valid_o & m_ready_i) <= 2), 1);
            end
            if (m_valid_o && m_ready_i) begin
                check("beat_data", int'(m_data_o), (v.addr + popped) % DEPTH);
                popped++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check("done_with_last", popped, v.len);
            end
            if (done_cyc >= 0 && c > done_cyc) begin
                check("post_busy", int'(busy_o), 0);
                check("post_valid", int'(m_valid_o), 0);
            end
            prev_stall = m_valid_o & ~m_ready_i;
            prev_data  = m_data_o;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start_i = 1'b0;
        check("beats_total", popped, v.len);
        check("issues_total", issued, v.len);
        check("done_count", done_cnt, 1);
        if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
        check("ram_din_zero", int'(ram_din_o), 0);
    endtask

    vec_t vecs[7];

    initial begin
        for (int k = 0; k < int'(DEPTH); k++) mem[k] = DATA_W'(k);
        rst_i = 1'b1; start_i = 1'b0; addr_i = '0; len_i = '0; m_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_ram_en", int'(ram_en_o), 0);
        check("rst_ram_addr", int'(ram_addr_o), 0);
        check("rst_valid", int'(m_valid_o), 0);

        vecs[0] = '{addr: 4,  len: 8,  mode: 0, exp_done: 9,  repulse: -1};
        vecs[1] = '{addr: 62, len: 4,  mode: 0, exp_done: 5,  repulse: -1};
        vecs[2] = '{addr: 0,  len: 16, mode: 1, exp_done: -1, repulse: -1};
        vecs[3] = '{addr: 0,  len: 0,  mode: 0, exp_done: 1,  repulse: -1};
        vecs[4] = '{addr: 0,  len: 64, mode: 0, exp_done: 65, repulse: -1};
        vecs[5] = '{addr: 60, len: 5,  mode: 2, exp_done: 7,  repulse: -1};
        vecs[6] = '{addr: 20, len: 8,  mode: 0, exp_done: 9,  repulse: 3};
        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // Reset after three beats of a burst; a start in the reset cycle must be dropped.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start_i = (c == 0) || (c == 5);
            addr_i  = (c == 5) ? ADDR_W'(0) : ADDR_W'(30);
            len_i   = (c == 5) ? (ADDR_W+1)'(5) : (ADDR_W+1)'(10);
            rst_i   = (c == 5);
            m_ready_i = 1'b1;
            #1;
            if (c >= 2 && c <= 4) begin
                check("pre_rst_valid", int'(m_valid_o), 1);
                check("pre_rst_data", int'(m_data_o), 30 + c - 2);
            end
            if (c >= 6) begin
                check("aborted_valid", int'(m_valid_o), 0);
                check("aborted_done", int'(done_o), 0);
                check("aborted_busy", int'(busy_o), 0);
                check("aborted_ram_en", int'(ram_en_o), 0);
            end
            if (c == 6) check("aborted_ram_addr", int'(ram_addr_o), 0);
        end
        start_i = 1'b0;
        rst_i   = 1'b0;
        run_burst('{addr: 5, len: 3, mode: 0, exp_done: 4, repulse: -1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter DATA_W, default 8: RAM word and stream data width.
REQ-002 Parameter ADDR_W, default 6: RAM address width; depth 2**ADDR_W.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  one-cycle request to begin a burst read.
REQ-006 addr_i  in  ADDR_W  burst start address, sampled with start_i.
REQ-007 len_i  in  ADDR_W+1  burst length in words (0..2**ADDR_W), sampled with start_i.
REQ-008 busy_o  out  1  burst in progress.
REQ-009 done_o  out  1  one-cycle pulse on burst completion.
REQ-010 ram_en_o  out  1  RAM port enable; connects to the dual-port RAM enable of one port.
REQ-011 ram_we_o  out  1  RAM write enable; held constant 0.
REQ-012 ram_addr_o  out  ADDR_W  RAM read address.
REQ-013 ram_din_o  out  DATA_W  RAM write data; held constant 0.
REQ-014 ram_dout_i  in  DATA_W  RAM registered read data, valid the cycle after ram_en_o=1.
REQ-015 m_valid_o  out  1  stream data valid.
REQ-016 m_data_o  out  DATA_W  stream data.
REQ-017 m_ready_i  in  1  stream consumer ready; transfer when m_valid_o & m_ready_i.

Function
REQ-018 States: IDLE, RUN, FLUSH; encoding free.
REQ-019 IDLE: start_i=1 loads addr/len, goes RUN; busy_o=1 from the next cycle.
REQ-020 start_i while busy_o=1 is ignored; in-flight burst unaffected.
REQ-021 len_i=0: no RAM access, no stream beats; done_o pulses the cycle after start_i, busy_o stays 0.
REQ-022 RUN: one read issued per cycle (ram_en_o=1, ram_addr_o=current address) when words remain to issue and (buffer occupancy + reads in flight − pop this cycle) < 2.
REQ-023 Pop this cycle = m_valid_o & m_ready_i; combinational path m_ready_i -> ram_en_o permitted.
REQ-024 Read latency exactly 1: ram_dout_i sampled into the output buffer the cycle after each issue, never otherwise.
REQ-025 Output buffer: 2-entry FIFO; m_data_o = head entry; order equals issue order.
REQ-026 m_data_o and m_valid_o stable while m_valid_o=1 and m_ready_i=0.
REQ-027 Sustained throughput 1 word/cycle when m_ready_i held 1; first beat m_valid_o=1 two cycles after start_i.
REQ-028 Address increments by 1 per issue, wraps modulo 2**ADDR_W (2**ADDR_W−1 -> 0).
REQ-029 Remaining-issue counter ADDR_W+1 bits, decrements per issue; reaching 0 moves RUN -> FLUSH.
REQ-030 FLUSH: no issues; waits until buffer empty and nothing in flight after the final pop.
REQ-031 done_o=1 in the cycle of the final handshake; state returns to IDLE and busy_o=0 the next cycle.
REQ-032 ram_en_o=0 whenever no read is issued; ram_we_o never 1.

Reset
REQ-033 rst_i=1 at any clock edge: state IDLE, counters 0, buffer emptied, in-flight read discarded.
REQ-034 Outputs after reset: busy_o=0, done_o=0, ram_en_o=0, ram_addr_o=0, m_valid_o=0; m_data_o don't-care.
REQ-035 Reset mid-burst: no further beats and no done_o for the aborted burst; start_i in the reset cycle ignored.

Verification
REQ-036 RAM preloaded mem[k]=k; start addr=4,len=8, m_ready_i=1 -> beats 4..11 on 8 consecutive cycles, first 2 cycles after start, done_o with beat 11.
REQ-037 ADDR_W=6, start addr=62,len=4 -> beats 62,63,0,1; ram_addr_o wraps 63->0.
REQ-038 addr=0,len=16, m_ready_i random 50% -> all 16 beats in order, no loss/duplication, data stable during stalls, buffer never exceeds 2.
REQ-039 len=0 -> no ram_en_o, no m_valid_o, done_o pulse next cycle; len=64 (ADDR_W=6) -> full memory 0..63.
REQ-040 start_i re-pulsed mid-burst with different addr -> ignored; rst_i after 3 beats -> m_valid_o=0 next cycle, no done_o, new burst after reset runs correctly.
